// File: rtl/guess_scorer.sv
// Bull-and-cow scoring engine: generates a 3-digit secret, scores guesses, tracks tries and win/lose.
// Build option: define BC_FIXED_SECRET_EN to load FIXED_SECRET in GEN instead of drawing from the LFSR.
module guess_scorer #(
    parameter int          MAX_TRIES    = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [11:0] FIXED_SECRET = 12'h123
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] iNum1,
    input  logic [3:0] iNum2,
    input  logic [3:0] iNum3,
    input  logic       iNumRdy,
    input  logic       iNewGame,
    output logic [1:0] oBulls,
    output logic [1:0] oCows,
    output logic       oResultVld,
    output logic       oInvalid,
    output logic [3:0] oTries,
    output logic       oWin,
    output logic       oLose,
    output logic       oBusy
);
    typedef enum logic [2:0] {GEN, IDLE, CHECK, SCORE, RESULT, DONE} state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q;
    logic [2:0][3:0]  sec_q, sec_d;     // [0] is the leftmost digit
    logic [2:0][3:0]  g_q, g_d;
    logic [1:0]       gcnt_q, gcnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       bull_q, bull_d, cow_q, cow_d;
    logic [1:0]       bulls_q, bulls_d, cows_q, cows_d;
    logic [3:0]       tries_q, tries_d;
    logic             vld_q, vld_d, inv_q, inv_d;
    logic             win_q, win_d, lose_q, lose_d, busy_q, busy_d;
    logic [3:0]       gi;
    logic             bhit, chit, bad_guess;

    wire lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        state_d = state_q;  sec_d  = sec_q;   g_d     = g_q;
        gcnt_d  = gcnt_q;   idx_d  = idx_q;   bull_d  = bull_q;  cow_d = cow_q;
        bulls_d = bulls_q;  cows_d = cows_q;  tries_d = tries_q;
        win_d   = win_q;    lose_d = lose_q;  vld_d   = 1'b0;    inv_d = 1'b0;
        gi      = g_q[idx_q];
        bhit    = (gi == sec_q[idx_q]);
        chit    = 1'b0;
        for (int j = 0; j < 3; j++)
            if (j != int'(idx_q) && gi == sec_q[j]) chit = 1'b1;
        bad_guess = (g_q[0] > 4'd9) || (g_q[1] > 4'd9) || (g_q[2] > 4'd9) ||
                    (g_q[0] == g_q[1]) || (g_q[0] == g_q[2]) || (g_q[1] == g_q[2]);

        case (state_q)
            GEN: begin
`ifdef BC_FIXED_SECRET_EN
                sec_d   = {FIXED_SECRET[3:0], FIXED_SECRET[7:4], FIXED_SECRET[11:8]};
                state_d = IDLE;
`else
                // Only digits already accepted this game take part in the duplicate test.
                if (lfsr_q[3:0] <= 4'd9 &&
                    (gcnt_q == 2'd0 || lfsr_q[3:0] != sec_q[0]) &&
                    (gcnt_q <  2'd2 || lfsr_q[3:0] != sec_q[1])) begin
                    sec_d[gcnt_q] = lfsr_q[3:0];
                    gcnt_d        = gcnt_q + 2'd1;
                    if (gcnt_q == 2'd2) begin
                        gcnt_d  = 2'd0;
                        state_d = IDLE;
                    end
                end
`endif
            end
            IDLE: if (iNumRdy) begin
                g_d     = {iNum3, iNum2, iNum1};
                state_d = CHECK;
            end
            CHECK: if (bad_guess) begin
                inv_d   = 1'b1;
                state_d = IDLE;
            end else begin
                bull_d  = 2'd0;
                cow_d   = 2'd0;
                idx_d   = 2'd0;
                state_d = SCORE;
            end
            SCORE: begin
                bull_d = bull_q + {1'b0, bhit};
                cow_d  = cow_q + {1'b0, chit};
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd2) state_d = RESULT;
            end
            RESULT: begin
                bulls_d = bull_q;
                cows_d  = cow_q;
                vld_d   = 1'b1;
                tries_d = tries_q + 4'd1;
                if (bull_q == 2'd3) begin
                    win_d   = 1'b1;
                    state_d = DONE;
                end else if (tries_q + 4'd1 == 4'(MAX_TRIES)) begin
                    lose_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE:    ;
            default: state_d = GEN;
        endcase

        // A new game aborts anything in flight, including a result about to be posted.
        if (iNewGame) begin
            state_d = GEN;    gcnt_d = 2'd0;
            tries_d = 4'd0;   win_d  = 1'b0;  lose_d = 1'b0;
            bulls_d = 2'd0;   cows_d = 2'd0;  vld_d  = 1'b0;  inv_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GEN;   lfsr_q <= LFSR_SEED;  sec_q   <= '0;  g_q    <= '0;
            gcnt_q  <= '0;    idx_q  <= '0;         bull_q  <= '0;  cow_q  <= '0;
            bulls_q <= '0;    cows_q <= '0;         tries_q <= '0;
            vld_q   <= 1'b0;  inv_q  <= 1'b0;       win_q   <= 1'b0;
            lose_q  <= 1'b0;  busy_q <= 1'b0;
        end else begin
            state_q <= state_d;  lfsr_q <= {lfsr_q[14:0], lfsr_fb};
            sec_q   <= sec_d;    g_q    <= g_d;     gcnt_q  <= gcnt_d;  idx_q <= idx_d;
            bull_q  <= bull_d;   cow_q  <= cow_d;   bulls_q <= bulls_d; cows_q <= cows_d;
            tries_q <= tries_d;  vld_q  <= vld_d;   inv_q   <= inv_d;
            win_q   <= win_d;    lose_q <= lose_d;  busy_q  <= busy_d;
        end
    end

    assign oBulls     = bulls_q;
    assign oCows      = cows_q;
    assign oResultVld = vld_q;
    assign oInvalid   = inv_q;
    assign oTries     = tries_q;
    assign oWin       = win_q;
    assign oLose      = lose_q;
    assign oBusy      = busy_q;
endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer: a transaction-level game model checks the outputs every cycle.
module tb_guess_scorer;
    localparam int MAXT = 8;
`ifdef BC_FIXED_SECRET_EN
    localparam logic [11:0] FIRST_SEC = 12'h123;
`else
    localparam logic [11:0] FIRST_SEC = 12'h137;  // first three acceptable nibbles of 16'hACE1
`endif

    logic clk = 1'b0, reset = 1'b1, iNumRdy = 1'b0, iNewGame = 1'b0;
    logic [3:0] iNum1 = '0, iNum2 = '0, iNum3 = '0;
    logic [1:0] oBulls, oCows;
    logic       oResultVld, oInvalid, oWin, oLose, oBusy;
    logic [3:0] oTries;

    guess_scorer #(.MAX_TRIES(MAXT)) dut (
        .clk(clk), .reset(reset), .iNum1(iNum1), .iNum2(iNum2), .iNum3(iNum3),
        .iNumRdy(iNumRdy), .iNewGame(iNewGame), .oBulls(oBulls), .oCows(oCows),
        .oResultVld(oResultVld), .oInvalid(oInvalid), .oTries(oTries),
        .oWin(oWin), .oLose(oLose), .oBusy(oBusy));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [3:0] g1, g2, g3; } ev_t;
    ev_t q[$];
    int  m_tries = 0, m_bulls = 0, m_cows = 0, m_win = 0, m_lose = 0;
    int  m_sec[3];
    int  clr_cyc = -1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit gvalid(input logic [3:0] a, b, c);
        return a <= 9 && b <= 9 && c <= 9 && a != b && a != c && b != c;
    endfunction

    // Plain counting definition of bulls and cows against the model's secret.
    function automatic void score(input logic [3:0] a, b, c, output int nb, output int nc);
        int g[3];
        g[0] = a; g[1] = b; g[2] = c;
        nb = 0; nc = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (g[i] == m_sec[j]) begin
                    if (i == j) nb++; else nc++;
                end
    endfunction

    always @(negedge clk) begin
        ev_t ev;
        int  nb, nc;
        if (cyc == clr_cyc) begin
            q.delete();
            m_tries = 0; m_bulls = 0; m_cows = 0; m_win = 0; m_lose = 0;
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = q.pop_front();
            if (gvalid(ev.g1, ev.g2, ev.g3)) begin
                chk("result_pulse", oResultVld, 1);
                chk("no_invalid", oInvalid, 0);
                score(ev.g1, ev.g2, ev.g3, nb, nc);
                m_bulls = nb; m_cows = nc; m_tries++;
                if (nb == 3) m_win = 1;
                else if (m_tries == MAXT) m_lose = 1;
            end else begin
                chk("invalid_pulse", oInvalid, 1);
                chk("no_result", oResultVld, 0);
            end
        end else begin
            chk("idle_result", oResultVld, 0);
            chk("idle_invalid", oInvalid, 0);
        end
        chk("tries", oTries, 16'(m_tries));
        chk("win", oWin, 16'(m_win));
        chk("lose", oLose, 16'(m_lose));
        chk("bulls", oBulls, 16'(m_bulls));
        chk("cows", oCows, 16'(m_cows));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic newgame();
        iNewGame = 1'b1; clr_cyc = cyc + 1;
        tick();
        iNewGame = 1'b0;
    endtask

    task automatic issue(input logic [3:0] a, b, c, input bit accept);
        ev_t ev;
        iNum1 = a; iNum2 = b; iNum3 = c; iNumRdy = 1'b1;
        if (accept) begin
            ev.due = cyc + (gvalid(a, b, c) ? 6 : 2);
            ev.g1 = a; ev.g2 = b; ev.g3 = c;
            q.push_back(ev);
        end
        tick();
        iNumRdy = 1'b0;
    endtask

    task automatic guess(input logic [3:0] a, b, c, input bit accept);
        issue(a, b, c, accept);
        repeat (7) tick();
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        tick();
        while (oBusy && n < lim) begin tick(); n++; end
        total++;
        if (oBusy) begin
            bad++;
            $display("FAIL gen_timeout: busy still %0d after %0d clks", oBusy, lim);
        end
        for (int i = 0; i < 3; i++) m_sec[i] = int'(dut.sec_q[i]);
        total++;
        if (!gvalid(4'(m_sec[0]), 4'(m_sec[1]), 4'(m_sec[2]))) begin
            bad++;
            $display("FAIL secret_digits: got %0d%0d%0d want 3 distinct BCD", m_sec[0], m_sec[1], m_sec[2]);
        end
    endtask

    function automatic void spare(output logic [3:0] a, b, c);
        int got[$];
        for (int d = 0; d < 10; d++)
            if (d != m_sec[0] && d != m_sec[1] && d != m_sec[2]) got.push_back(d);
        a = 4'(got[0]); b = 4'(got[1]); c = 4'(got[2]);
    endfunction

    initial begin
        logic [3:0] a, b, c;
        repeat (3) tick();
        chk("rst_busy", oBusy, 0);
        chk("rst_tries", oTries, 0);
        reset = 1'b0;
        wait_idle(200);
        chk("first_secret", {4'(m_sec[0]), 4'(m_sec[1]), 4'(m_sec[2])}, FIRST_SEC);

        // Winning guess, then a guess in DONE that must be ignored.
        guess(4'(m_sec[0]), 4'(m_sec[1]), 4'(m_sec[2]), 1);
        chk("win_bulls", oBulls, 3);
        chk("win_cows", oCows, 0);
        chk("win_tries", oTries, 1);
        chk("win_flag", oWin, 1);
        guess(4'(m_sec[0]), 4'(m_sec[1]), 4'(m_sec[2]), 0);
        chk("done_tries", oTries, 1);

        // Reversed secret and disjoint digits.
        newgame(); wait_idle(200);
        guess(4'(m_sec[2]), 4'(m_sec[1]), 4'(m_sec[0]), 1);
        chk("rev_bulls", oBulls, 1);
        chk("rev_cows", oCows, 2);
        spare(a, b, c);
        guess(a, b, c, 1);
        chk("miss_bulls", oBulls, 0);
        chk("miss_cows", oCows, 0);
        chk("miss_tries", oTries, 2);

        // Rejected guesses.
        newgame(); wait_idle(200);
        guess(4'(m_sec[0]), 4'(m_sec[0]), a, 1);
        guess(4'(m_sec[0]), 4'(m_sec[1]), 4'hA, 1);
        chk("inv_tries", oTries, 0);

        // Run out of tries, then a dropped 9th guess.
        spare(a, b, c);
        for (int i = 0; i < MAXT; i++) guess(a, b, c, 1);
        chk("lose_tries", oTries, 8);
        chk("lose_flag", oLose, 1);
        guess(a, b, c, 0);
        newgame();
        chk("ng_tries", oTries, 0);
        chk("ng_lose", oLose, 0);
        chk("ng_busy", oBusy, 1);
        wait_idle(200);

        // New game during SCORE discards the result.
        issue(4'(m_sec[0]), 4'(m_sec[1]), 4'(m_sec[2]), 1);
        tick(); tick();
        newgame();
        wait_idle(200);
        chk("abort_tries", oTries, 0);

        // New game and guess together, then a guess during GEN: both dropped.
        iNewGame = 1'b1; iNumRdy = 1'b1; clr_cyc = cyc + 1;
        tick();
        iNewGame = 1'b0; iNumRdy = 1'b0;
        guess(4'(m_sec[0]), 4'(m_sec[1]), 4'(m_sec[2]), 0);
        wait_idle(200);
        chk("drop_tries", oTries, 0);

        // Reset in the middle of scoring restores the power-on secret.
        issue(4'(m_sec[0]), 4'(m_sec[1]), 4'(m_sec[2]), 1);
        tick();
        reset = 1'b1; clr_cyc = cyc + 1;
        tick(); tick();
        chk("midrst_busy", oBusy, 0);
        reset = 1'b0;
        wait_idle(200);
        chk("midrst_secret", {4'(m_sec[0]), 4'(m_sec[1]), 4'(m_sec[2])}, FIRST_SEC);

        // Many new games: every secret must be legal and GEN must finish in time.
        for (int k = 0; k < 1000; k++) begin
            newgame();
            wait_idle(200);
            if (k % 100 == 0) guess(4'(m_sec[1]), 4'(m_sec[2]), 4'(m_sec[0]), 1);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
